// File: rtl/audio_mixer.sv
// Stereo voice mixer. Accumulates one channel per clock, applies master volume,
// saturates to 16-bit signed and hands the sample off with a valid/ready handshake.
module audio_mixer #(
    parameter int NUM_CH    = 4,
    parameter int VOL_SHIFT = 6
) (
    input  logic                 clk_50mhz,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic [NUM_CH*16-1:0] ch_left_in,
    input  logic [NUM_CH*16-1:0] ch_right_in,
    input  logic [NUM_CH-1:0]    ch_mute,
    input  logic [6:0]           master_vol,
    input  logic                 clear_flags,
    output logic [15:0]          mix_left,
    output logic [15:0]          mix_right,
    output logic                 mix_valid,
    input  logic                 mix_ready,
    output logic                 clip,
    output logic                 overrun
);

    localparam int IDXW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ACCW = 16 + $clog2(NUM_CH) + 1;
    localparam int PW   = ACCW + 8;

    localparam logic [6:0]           UNITY   = 7'(2 ** VOL_SHIFT);
    localparam logic [IDXW-1:0]      LAST_CH = IDXW'(NUM_CH - 1);
    localparam logic signed [PW-1:0] SAT_MAX = PW'(32767);
    localparam logic signed [PW-1:0] SAT_MIN = PW'(-32768);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SCALE,
        OUTPUT
    } state_t;

    state_t                 state_q, state_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic signed [ACCW-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic signed [PW-1:0]   prod_l_q, prod_l_d, prod_r_q, prod_r_d;
    logic                   scale_ph_q, scale_ph_d;
    logic [NUM_CH*16-1:0]   snap_l_q, snap_l_d, snap_r_q, snap_r_d;
    logic [NUM_CH-1:0]      snap_mute_q, snap_mute_d;
    logic [6:0]             vol_q, vol_d;
    logic [15:0]            mix_l_q, mix_l_d, mix_r_q, mix_r_d;
    logic                   valid_q, valid_d;
    logic                   clip_q, clip_d;
    logic                   overrun_q, overrun_d;

    logic                   take_snap;
    logic signed [15:0]     term_l, term_r;
    logic [16:0]            sat_l, sat_r;
    logic [6:0]             vol_clamped;

    // Returns {clipped, value} after the volume shift.
    function automatic logic [16:0] saturate(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] r;
        r = p >>> VOL_SHIFT;
        if (r > SAT_MAX) begin
            return {1'b1, 16'h7FFF};
        end else if (r < SAT_MIN) begin
            return {1'b1, 16'h8000};
        end else begin
            return {1'b0, r[15:0]};
        end
    endfunction

    assign vol_clamped = (master_vol > UNITY) ? UNITY : master_vol;
    assign term_l      = snap_mute_q[idx_q] ? 16'sd0 : $signed(snap_l_q[{idx_q, 4'b0000} +: 16]);
    assign term_r      = snap_mute_q[idx_q] ? 16'sd0 : $signed(snap_r_q[{idx_q, 4'b0000} +: 16]);
    assign sat_l       = saturate(prod_l_q);
    assign sat_r       = saturate(prod_r_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_l_d     = acc_l_q;
        acc_r_d     = acc_r_q;
        prod_l_d    = prod_l_q;
        prod_r_d    = prod_r_q;
        scale_ph_d  = scale_ph_q;
        snap_l_d    = snap_l_q;
        snap_r_d    = snap_r_q;
        snap_mute_d = snap_mute_q;
        vol_d       = vol_q;
        mix_l_d     = mix_l_q;
        mix_r_d     = mix_r_q;
        valid_d     = valid_q;
        clip_d      = clip_q & ~clear_flags;
        overrun_d   = overrun_q & ~clear_flags;
        take_snap   = 1'b0;

        case (state_q)
            IDLE: begin
                take_snap = sample_tick;
            end
            ACCUM: begin
                if (sample_tick) overrun_d = 1'b1;
                acc_l_d = acc_l_q + ACCW'(term_l);
                acc_r_d = acc_r_q + ACCW'(term_r);
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_CH) begin
                    state_d    = SCALE;
                    scale_ph_d = 1'b0;
                end
            end
            SCALE: begin
                if (sample_tick) overrun_d = 1'b1;
                // Multiply and saturate are split across two cycles to keep the multiplier off the clamp path.
                if (!scale_ph_q) begin
                    prod_l_d   = PW'(acc_l_q) * PW'($signed({1'b0, vol_q}));
                    prod_r_d   = PW'(acc_r_q) * PW'($signed({1'b0, vol_q}));
                    scale_ph_d = 1'b1;
                end else begin
                    mix_l_d = sat_l[15:0];
                    mix_r_d = sat_r[15:0];
                    valid_d = 1'b1;
                    if (sat_l[16] || sat_r[16]) clip_d = 1'b1;
                    scale_ph_d = 1'b0;
                    state_d    = OUTPUT;
                end
            end
            OUTPUT: begin
                if (mix_ready) begin
                    valid_d   = 1'b0;
                    state_d   = IDLE;
                    take_snap = sample_tick;
                end else if (sample_tick) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take_snap) begin
            snap_l_d    = ch_left_in;
            snap_r_d    = ch_right_in;
            snap_mute_d = ch_mute;
            vol_d       = vol_clamped;
            acc_l_d     = '0;
            acc_r_d     = '0;
            idx_d       = '0;
            state_d     = ACCUM;
        end
    end

    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            prod_l_q    <= '0;
            prod_r_q    <= '0;
            scale_ph_q  <= 1'b0;
            snap_l_q    <= '0;
            snap_r_q    <= '0;
            snap_mute_q <= '0;
            vol_q       <= '0;
            mix_l_q     <= '0;
            mix_r_q     <= '0;
            valid_q     <= 1'b0;
            clip_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_l_q     <= acc_l_d;
            acc_r_q     <= acc_r_d;
            prod_l_q    <= prod_l_d;
            prod_r_q    <= prod_r_d;
            scale_ph_q  <= scale_ph_d;
            snap_l_q    <= snap_l_d;
            snap_r_q    <= snap_r_d;
            snap_mute_q <= snap_mute_d;
            vol_q       <= vol_d;
            mix_l_q     <= mix_l_d;
            mix_r_q     <= mix_r_d;
            valid_q     <= valid_d;
            clip_q      <= clip_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mix_left  = mix_l_q;
    assign mix_right = mix_r_q;
    assign mix_valid = valid_q;
    assign clip      = clip_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_audio_mixer.sv
// Directed bench for audio_mixer: passthrough, saturation, volume, mute/snapshot,
// backpressure/overrun and mid-mix reset, with hand-computed expectations.
module tb_audio_mixer;

    localparam int NUM_CH = 4;

    logic                 clk_50mhz = 1'b0;
    logic                 reset = 1'b1;
    logic                 sample_tick = 1'b0;
    logic [NUM_CH*16-1:0] ch_left_in = '0;
    logic [NUM_CH*16-1:0] ch_right_in = '0;
    logic [NUM_CH-1:0]    ch_mute = '0;
    logic [6:0]           master_vol = 7'd64;
    logic                 clear_flags = 1'b0;
    logic [15:0]          mix_left, mix_right;
    logic                 mix_valid;
    logic                 mix_ready = 1'b1;
    logic                 clip, overrun;

    int n_checks = 0;
    int n_pass   = 0;
    int lat;
    int bad;

    audio_mixer #(.NUM_CH(NUM_CH), .VOL_SHIFT(6)) dut (
        .clk_50mhz   (clk_50mhz),
        .reset       (reset),
        .sample_tick (sample_tick),
        .ch_left_in  (ch_left_in),
        .ch_right_in (ch_right_in),
        .ch_mute     (ch_mute),
        .master_vol  (master_vol),
        .clear_flags (clear_flags),
        .mix_left    (mix_left),
        .mix_right   (mix_right),
        .mix_valid   (mix_valid),
        .mix_ready   (mix_ready),
        .clip        (clip),
        .overrun     (overrun)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic set_ch(input int idx, input int l, input int r);
        ch_left_in[idx*16 +: 16]  = 16'(l);
        ch_right_in[idx*16 +: 16] = 16'(r);
    endtask

    task automatic clear_all_ch();
        ch_left_in  = '0;
        ch_right_in = '0;
        ch_mute     = '0;
    endtask

    task automatic do_tick();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    // Cycles from the current edge until mix_valid is seen; -1 on timeout.
    task automatic wait_valid(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (mix_valid) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        #2;
        check("rst_left", $signed(mix_left), 0);
        check("rst_right", $signed(mix_right), 0);
        check("rst_valid", int'(mix_valid), 0);
        check("rst_clip", int'(clip), 0);
        check("rst_overrun", int'(overrun), 0);
        step();
        reset = 1'b0;
        step();

        // Passthrough with latency
        clear_all_ch();
        set_ch(0, 1000, -1000);
        master_vol = 7'd64;
        mix_ready  = 1'b1;
        do_tick();
        wait_valid(lat);
        check("pass_latency", lat, 6);
        check("pass_left", $signed(mix_left), 1000);
        check("pass_right", $signed(mix_right), -1000);
        check("pass_clip", int'(clip), 0);
        step();
        check("pass_valid_1cyc", int'(mix_valid), 0);
        check("pass_data_kept", $signed(mix_left), 1000);

        // Saturation and sticky clip
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 30000, -30000);
        do_tick();
        wait_valid(lat);
        check("sat_left", $signed(mix_left), 32767);
        check("sat_right", $signed(mix_right), -32768);
        check("sat_clip", int'(clip), 1);
        step();
        clear_all_ch();
        set_ch(0, 1000, -1000);
        do_tick();
        wait_valid(lat);
        check("sticky_left", $signed(mix_left), 1000);
        check("sticky_clip", int'(clip), 1);
        step();
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        check("clip_cleared", int'(clip), 0);

        // Volume and rounding toward -inf
        clear_all_ch();
        set_ch(0, 1001, -1001);
        master_vol = 7'd32;
        do_tick();
        wait_valid(lat);
        check("vol32_left", $signed(mix_left), 500);
        check("vol32_right", $signed(mix_right), -501);
        step();
        master_vol = 7'd100;
        do_tick();
        wait_valid(lat);
        check("vol100_left", $signed(mix_left), 1001);
        check("vol100_right", $signed(mix_right), -1001);
        step();
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 30000, -30000);
        master_vol = 7'd0;
        do_tick();
        wait_valid(lat);
        check("vol0_left", $signed(mix_left), 0);
        check("vol0_right", $signed(mix_right), 0);
        check("vol0_clip", int'(clip), 0);
        step();

        // Mute and snapshot isolation
        clear_all_ch();
        master_vol = 7'd64;
        set_ch(0, 5000, -7);
        set_ch(1, 5000, 3);
        ch_mute = 4'b0010;
        do_tick();
        step();
        step();
        set_ch(0, 0, 0);
        ch_mute = 4'b0000;
        wait_valid(lat);
        check("mute_left", $signed(mix_left), 5000);
        check("mute_right", $signed(mix_right), -7);
        step();

        // Backpressure and overrun
        clear_all_ch();
        set_ch(0, 1234, -4321);
        mix_ready = 1'b0;
        do_tick();
        wait_valid(lat);
        check("bp_latency", lat, 6);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                set_ch(0, 1, 1);
                sample_tick = 1'b1;
            end
            step();
            sample_tick = 1'b0;
            if (!mix_valid || $signed(mix_left) != 1234 || $signed(mix_right) != -4321) bad++;
        end
        check("bp_hold_bad_cycles", bad, 0);
        check("bp_overrun", int'(overrun), 1);
        check("bp_left", $signed(mix_left), 1234);
        mix_ready = 1'b1;
        step();
        check("bp_xfer_valid", int'(mix_valid), 0);
        check("bp_xfer_data_kept", $signed(mix_right), -4321);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (mix_valid) bad++;
        end
        check("bp_idle_after", bad, 0);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        check("overrun_cleared", int'(overrun), 0);

        // Tick on the transfer edge
        set_ch(0, 1234, -4321);
        mix_ready = 1'b0;
        do_tick();
        wait_valid(lat);
        step();
        set_ch(0, -2000, 2500);
        mix_ready   = 1'b1;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check("xt_valid", int'(mix_valid), 0);
        check("xt_overrun", int'(overrun), 0);
        wait_valid(lat);
        check("xt_latency", lat, 6);
        check("xt_left", $signed(mix_left), -2000);
        check("xt_right", $signed(mix_right), 2500);
        step();

        // Reset mid-ACCUM
        clear_all_ch();
        set_ch(0, 7000, 7000);
        do_tick();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check("accum_overrun", int'(overrun), 1);
        step();
        #2;
        reset = 1'b1;
        #1;
        check("mrst_left", $signed(mix_left), 0);
        check("mrst_right", $signed(mix_right), 0);
        check("mrst_overrun", int'(overrun), 0);
        check("mrst_valid", int'(mix_valid), 0);
        step();
        step();
        reset = 1'b0;
        step();
        clear_all_ch();
        set_ch(0, 200, 0);
        set_ch(1, 300, -50);
        do_tick();
        wait_valid(lat);
        check("fresh_latency", lat, 6);
        check("fresh_left", $signed(mix_left), 500);
        check("fresh_right", $signed(mix_right), -50);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
